// File: rtl/dsm2_dac_stereo_pkg.sv
// Shared constants and helpers for the stereo second-order delta-sigma DAC.
// Widths, feedback levels, integrator limits and the dither LFSR definition
// live here so the channel and the top agree on them.
package dsm2_dac_stereo_pkg;

    localparam int DSM_IN_W    = 18;        // Q1.17 input sample
    localparam int DSM_INT_W   = 24;        // integrator width
    localparam int DSM_SUM_W   = 26;        // headroom for unsaturated sums
    localparam int DSM_FB_POS  = 131071;    // feedback when output bit is 1
    localparam int DSM_FB_NEG  = -131072;   // feedback when output bit is 0
    localparam int DSM_INT_MAX = 8388607;
    localparam int DSM_INT_MIN = -8388608;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10
    localparam logic [15:0] DSM_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] DSM_LFSR_TAPS = 16'hB400;

    typedef logic signed [DSM_SUM_W-1:0] dsm_sum_t;
    typedef logic signed [DSM_INT_W-1:0] dsm_int_t;

    // Clamp a wide sum into the integrator range.
    function automatic dsm_int_t sat24(input dsm_sum_t v);
        dsm_int_t r;
        if (v > dsm_sum_t'(DSM_INT_MAX)) begin
            r = dsm_int_t'(DSM_INT_MAX);
        end else if (v < dsm_sum_t'(DSM_INT_MIN)) begin
            r = dsm_int_t'(DSM_INT_MIN);
        end else begin
            r = v[DSM_INT_W-1:0];
        end
        return r;
    endfunction

    // Feedback bit shifted into the LFSR on each advance.
    function automatic logic lfsr_feedback(input logic [15:0] s);
        return ^(s & DSM_LFSR_TAPS);
    endfunction

endpackage

// File: rtl/dsm2_channel.sv
// One channel of the second-order delta-sigma modulator: two saturating
// 24-bit integrators and the registered 1-bit output. The loop state only
// moves on tick_en; between ticks everything holds.
module dsm2_channel
    import dsm2_dac_stereo_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                tick_en,
    input  logic [DSM_IN_W-1:0] x,
    input  logic [1:0]          d,
    output logic                out
);

    dsm_int_t r_int1;
    dsm_int_t r_int2;
    logic     r_out;

    dsm_sum_t w_xs;
    dsm_sum_t w_fb;
    dsm_sum_t w_d;
    dsm_sum_t w_sum1;
    dsm_sum_t w_sum2;
    dsm_int_t w_int1_n;
    dsm_int_t w_int2_n;

    // Next-state loop arithmetic; input is halved for loop stability.
    always_comb begin
        w_xs     = {{(DSM_SUM_W - DSM_IN_W + 1){x[DSM_IN_W-1]}}, x[DSM_IN_W-1:1]};
        w_fb     = r_out ? dsm_sum_t'(DSM_FB_POS) : dsm_sum_t'(DSM_FB_NEG);
        w_d      = {{(DSM_SUM_W - 2){d[1]}}, d};
        w_sum1   = {{(DSM_SUM_W - DSM_INT_W){r_int1[DSM_INT_W-1]}}, r_int1} + w_xs - w_fb;
        w_int1_n = sat24(w_sum1);
        w_sum2   = {{(DSM_SUM_W - DSM_INT_W){r_int2[DSM_INT_W-1]}}, r_int2}
                 + {{(DSM_SUM_W - DSM_INT_W){w_int1_n[DSM_INT_W-1]}}, w_int1_n}
                 - w_fb + w_d;
        w_int2_n = sat24(w_sum2);
    end

    // Commit integrators and the quantised output bit once per modulator tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_int1 <= '0;
            r_int2 <= '0;
            r_out  <= 1'b0;
        end else if (tick_en) begin
            r_int1 <= w_int1_n;
            r_int2 <= w_int2_n;
            r_out  <= ~w_int2_n[DSM_INT_W-1];
        end
    end

    assign out = r_out;

endmodule

// File: rtl/dsm2_dac_stereo.sv
// Stereo second-order delta-sigma DAC front end. Holds the last strobed
// sample per channel, divides clk down to the modulator rate and drives two
// dsm2_channel instances. Optional TPDF-like +/-1 dither into the second
// integrator is enabled by defining DSM_DITHER_EN.
module dsm2_dac_stereo
    import dsm2_dac_stereo_pkg::*;
#(
    parameter int TICK_DIV = 16
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_in_rdy,
    input  logic [DSM_IN_W-1:0] sample_in_l,
    input  logic [DSM_IN_W-1:0] sample_in_r,
    output logic                dac_out_l,
    output logic                dac_out_r,
    output logic                tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]             r_tick_cnt;
    logic                         r_tick;
    logic                         w_tick_en;
    logic [1:0]                   w_d;
    logic [1:0][DSM_IN_W-1:0]     w_in;
    logic [1:0]                   w_dac;

    assign w_tick_en = (r_tick_cnt == CNT_LAST);
    assign w_in      = {sample_in_r, sample_in_l};

    // Free-running modulator-rate divider, wraps at TICK_DIV-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick_en) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        end
    end

    // Tick flag trails the update edge by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tick_en;
        end
    end

`ifdef DSM_DITHER_EN
    logic [15:0] r_lfsr;

    // Dither source advances once per modulator update, shared by both channels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= DSM_LFSR_SEED;
        end else if (w_tick_en) begin
            r_lfsr <= {r_lfsr[14:0], lfsr_feedback(r_lfsr)};
        end
    end

    assign w_d = r_lfsr[0] ? 2'b01 : 2'b11;
`else
    assign w_d = 2'b00;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_ch
            logic [DSM_IN_W-1:0] r_x;

            // Capture the strobed sample; it is held until the next strobe.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_x <= '0;
                end else if (sample_in_rdy) begin
                    r_x <= w_in[gi];
                end
            end

            dsm2_channel u_ch (
                .clk     (clk),
                .reset   (reset),
                .tick_en (w_tick_en),
                .x       (r_x),
                .d       (w_d),
                .out     (w_dac[gi])
            );
        end
    endgenerate

    assign dac_out_l = w_dac[0];
    assign dac_out_r = w_dac[1];
    assign tick      = r_tick;

endmodule

// File: tb/tb_dsm2_dac_stereo.sv
// Directed bench for dsm2_dac_stereo: one instance at TICK_DIV=16 and one at
// TICK_DIV=1 share the same stimulus.
module tb_dsm2_dac_stereo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_in_rdy = 1'b0;
    logic [17:0] sample_in_l = '0;
    logic [17:0] sample_in_r = '0;
    logic        dl_s, dr_s, tk_s;
    logic        dl_f, dr_f, tk_f;

    int checks = 0;
    int errors = 0;

    // equation-level reference for the TICK_DIV=1 instance
    int   m_i1 [2];
    int   m_i2 [2];
    int   m_x  [2];
    logic m_out[2];

    always #5 clk = ~clk;

    dsm2_dac_stereo #(.TICK_DIV(16)) u_dut_slow (
        .clk(clk), .reset(reset), .sample_in_rdy(sample_in_rdy),
        .sample_in_l(sample_in_l), .sample_in_r(sample_in_r),
        .dac_out_l(dl_s), .dac_out_r(dr_s), .tick(tk_s)
    );

    dsm2_dac_stereo #(.TICK_DIV(1)) u_dut_fast (
        .clk(clk), .reset(reset), .sample_in_rdy(sample_in_rdy),
        .sample_in_l(sample_in_l), .sample_in_r(sample_in_r),
        .dac_out_l(dl_f), .dac_out_r(dr_f), .tick(tk_f)
    );

    function automatic int clamp24(input int v);
        if (v > 8388607)  return 8388607;
        if (v < -8388608) return -8388608;
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_i1[c] = 0; m_i2[c] = 0; m_x[c] = 0; m_out[c] = 1'b0;
        end
    endtask

    task automatic model_tick();
        for (int c = 0; c < 2; c++) begin
            int xs, fb, s1, s2;
            xs = m_x[c] >>> 1;
            fb = m_out[c] ? 131071 : -131072;
            s1 = clamp24(m_i1[c] + xs - fb);
            s2 = clamp24(m_i2[c] + s1 - fb);
            m_i1[c] = s1;
            m_i2[c] = s2;
            m_out[c] = (s2 >= 0);
        end
    endtask

    // One clock: inputs already driven, advance to the next negedge, update model.
    task automatic step_fast();
        @(negedge clk);
        model_tick();
        if (sample_in_rdy) begin
            m_x[0] = int'($signed(sample_in_l));
            m_x[1] = int'($signed(sample_in_r));
        end
        sample_in_rdy = 1'b0;
    endtask

    task automatic set_strobe(input int l, input int r);
        sample_in_rdy = 1'b1;
        sample_in_l   = 18'(l);
        sample_in_r   = 18'(r);
    endtask

    task automatic do_reset_release();
        @(negedge clk);
        reset = 1'b1;
        sample_in_rdy = 1'b0;
        sample_in_l = '0;
        sample_in_r = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int n;
        do_reset_release();
        set_strobe(65536, -65536);
        n = 0;
        do begin
            step_fast();
            n++;
        end while (!(dl_f === 1'b1 && n >= 8) && n < 200);
        checks++;
        if (dl_f !== 1'b1) begin
            errors++;
            $display("FAIL reset_setup: dac_out_l=%b, required 1 within 200 cycles", dl_f);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({dl_f, dr_f, tk_f} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async_fast: {l,r,tick}=%b required 000", {dl_f, dr_f, tk_f});
        end
        checks++;
        if ({dl_s, dr_s, tk_s} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async_slow: {l,r,tick}=%b required 000", {dl_s, dr_s, tk_s});
        end
        $display("reset asserted mid-cycle: fast %b%b%b slow %b%b%b", dl_f, dr_f, tk_f, dl_s, dr_s, tk_s);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_idle();
        logic exp_first[3] = '{1'b1, 1'b1, 1'b0};
        int   ones = 0;
        int   mism = 0;
        int   slow_first = -1;
        int   slow_idx = 0;
        logic [2:0] slow_bits = 3'b000;
        for (int t = 1; t <= 1024; t++) begin
            step_fast();
            if (t <= 3) begin
                checks++;
                if (dl_f !== exp_first[t-1] || dr_f !== exp_first[t-1]) begin
                    errors++;
                    $display("FAIL idle_tick%0d: l=%b r=%b required %b", t, dl_f, dr_f, exp_first[t-1]);
                end
                $display("idle tick %0d: l=%b r=%b", t, dl_f, dr_f);
            end
            if (dl_f === 1'b1) ones++;
            if (dl_f !== m_out[0] || dr_f !== m_out[1] || tk_f !== 1'b1) mism++;
            if (tk_s === 1'b1) begin
                if (slow_first < 0) slow_first = t;
                if (slow_idx < 3) slow_bits[slow_idx] = dl_s;
                slow_idx++;
            end
        end
        checks++;
        if (ones < 510 || ones > 514) begin
            errors++;
            $display("FAIL idle_density: ones=%0d required 512+-2", ones);
        end
        checks++;
        if (mism !== 0) begin
            errors++;
            $display("FAIL idle_model: %0d ticks differ, required 0", mism);
        end
        checks++;
        if (slow_first !== 16) begin
            errors++;
            $display("FAIL slow_first_tick: cycle=%0d required 16", slow_first);
        end
        checks++;
        if (slow_bits !== 3'b011 || slow_idx !== 64) begin
            errors++;
            $display("FAIL slow_first_bits: bits(t3..t1)=%b count=%0d required 011 count 64", slow_bits, slow_idx);
        end
        $display("idle: ones=%0d slow_first=%0d slow_ticks=%0d", ones, slow_first, slow_idx);
    endtask

    task automatic test_divider();
        int   last = -1;
        int   pulses = 0;
        int   bad_gap = 0;
        int   bad_chg = 0;
        logic prev_l = dl_s;
        logic prev_r = dr_s;
        for (int t = 1; t <= 320; t++) begin
            step_fast();
            if (tk_s === 1'b1) begin
                if (last >= 0 && (t - last) != 16) bad_gap++;
                last = t;
                pulses++;
            end else if (dl_s !== prev_l || dr_s !== prev_r) begin
                bad_chg++;
            end
            prev_l = dl_s;
            prev_r = dr_s;
        end
        checks++;
        if (pulses !== 20 || bad_gap !== 0) begin
            errors++;
            $display("FAIL divider_period: pulses=%0d bad_gaps=%0d required 20 and 0", pulses, bad_gap);
        end
        checks++;
        if (bad_chg !== 0) begin
            errors++;
            $display("FAIL divider_hold: %0d changes off-tick, required 0", bad_chg);
        end
        $display("divider: pulses=%0d gaps_bad=%0d changes_off_tick=%0d", pulses, bad_gap, bad_chg);
    endtask

    task automatic test_coincide();
        logic exp_z[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic exp_l[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int   mism = 0;
        do_reset_release();
        for (int t = 1; t <= 5; t++) begin
            step_fast();
            checks++;
            if (dl_f !== exp_z[t-1]) begin
                errors++;
                $display("FAIL coincide_pre%0d: l=%b required %b", t, dl_f, exp_z[t-1]);
            end
        end
        set_strobe(131071, -131072);
        for (int t = 6; t <= 40; t++) begin
            step_fast();
            if (t <= 11) begin
                checks++;
                if (dl_f !== exp_l[t-6]) begin
                    errors++;
                    $display("FAIL coincide_tick%0d: l=%b required %b", t, dl_f, exp_l[t-6]);
                end
                $display("coincide tick %0d: l=%b r=%b", t, dl_f, dr_f);
            end
            if (t == 7) begin
                checks++;
                if (dr_f !== 1'b1) begin
                    errors++;
                    $display("FAIL coincide_right7: r=%b required 1", dr_f);
                end
            end
            if (dl_f !== m_out[0] || dr_f !== m_out[1]) mism++;
        end
        checks++;
        if (mism !== 0) begin
            errors++;
            $display("FAIL coincide_model: %0d ticks differ, required 0", mism);
        end
    endtask

    task automatic test_back_to_back();
        int mism = 0;
        set_strobe(-100000, 100000);
        step_fast();
        set_strobe(50000, -50000);
        step_fast();
        for (int t = 0; t < 60; t++) begin
            step_fast();
            if (dl_f !== m_out[0] || dr_f !== m_out[1]) mism++;
        end
        checks++;
        if (mism !== 0) begin
            errors++;
            $display("FAIL back_to_back: %0d ticks differ, required 0", mism);
        end
        $display("back_to_back: model differences=%0d", mism);
    endtask

    task automatic test_dc();
        int ones_l = 0;
        int ones_r = 0;
        int mism = 0;
        do_reset_release();
        set_strobe(65536, -65536);
        for (int t = 0; t < 4096; t++) begin
            step_fast();
            if (dl_f === 1'b1) ones_l++;
            if (dr_f === 1'b1) ones_r++;
            if (dl_f !== m_out[0] || dr_f !== m_out[1]) mism++;
        end
        checks++;
        if (ones_l < 2520 || ones_l > 2600) begin
            errors++;
            $display("FAIL dc_left: ones=%0d required 2560+-40", ones_l);
        end
        checks++;
        if (ones_r < 1496 || ones_r > 1576) begin
            errors++;
            $display("FAIL dc_right: ones=%0d required 1536+-40", ones_r);
        end
        checks++;
        if (mism !== 0) begin
            errors++;
            $display("FAIL dc_model: %0d ticks differ, required 0", mism);
        end
        $display("dc: ones_l=%0d ones_r=%0d", ones_l, ones_r);
    endtask

    task automatic test_saturation();
        int ones = 0;
        int mism = 0;
        do_reset_release();
        set_strobe(-131072, -131072);
        for (int t = 0; t < 20000; t++) begin
            step_fast();
            if (dl_f === 1'b1) ones++;
            if (dl_f !== m_out[0] || dr_f !== m_out[1]) mism++;
        end
        checks++;
        if (ones < 4800 || ones > 5200) begin
            errors++;
            $display("FAIL sat_density: ones=%0d required 5000+-200", ones);
        end
        checks++;
        if (mism !== 0) begin
            errors++;
            $display("FAIL sat_model: %0d ticks differ, required 0", mism);
        end
        $display("saturation: ones=%0d of 20000", ones);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_divider();
        test_coincide();
        test_back_to_back();
        test_dc();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
